// File: rtl/maquina_vendas_if.sv
// rtl/maquina_vendas_if.sv - command and result signals between the vending stimulus source and maquina_vendas
interface maquina_vendas_if #(
    parameter int CARTEIRA_W = 16
);
    logic [1:0]            escolher;
    logic [1:0]            inserir_dinheiro;
    logic [1:0]            dar_troco;
    logic [7:0]            produto_escolhido;
    logic [7:0]            dinheiro_inserido;
    logic [23:0]           moedas_inseridas;
    logic [7:0]            produto_liberado;
    logic [7:0]            troco;
    logic                  moeda_valida;
    logic [1:0]            moeda_valor;
    logic [CARTEIRA_W-1:0] carteira;
    logic                  concluido;
    logic                  erro;
    logic [2:0]            estado;

    modport master (
        output escolher, inserir_dinheiro, dar_troco,
        output produto_escolhido, dinheiro_inserido, moedas_inseridas,
        input  produto_liberado, troco, moeda_valida, moeda_valor,
        input  carteira, concluido, erro, estado
    );

    modport slave (
        input  escolher, inserir_dinheiro, dar_troco,
        input  produto_escolhido, dinheiro_inserido, moedas_inseridas,
        output produto_liberado, troco, moeda_valida, moeda_valor,
        output carteira, concluido, erro, estado
    );
endinterface

// File: rtl/maquina_vendas.sv
// rtl/maquina_vendas.sv - vending controller: pricing, payment, wallet and greedy 100/50/25 change dispensing
// Optional coin-count validation of inserted money: define MAQ_VENDAS_VALIDA_MOEDAS_EN.
module maquina_vendas #(
    parameter int unsigned PRECO_1    = 50,
    parameter int unsigned PRECO_2    = 75,
    parameter int unsigned PRECO_3    = 100,
    parameter int          CARTEIRA_W = 16
) (
    input logic             clock,
    input logic             reset_n,
    maquina_vendas_if.slave bus
);
    typedef enum logic [2:0] {
        OCIOSO    = 3'd0,
        ESCOLHIDO = 3'd1,
        PAGO      = 3'd2,
        DEVOLVE   = 3'd3,
        FIM       = 3'd4
    } estado_t;

    estado_t               estado_q, estado_d;
    logic [7:0]            codigo_q, codigo_d;
    logic [7:0]            preco_q, preco_d;
    logic [7:0]            valor_q, valor_d;
    logic [7:0]            resto_q, resto_d;
    logic [7:0]            liberado_q, liberado_d;
    logic [7:0]            troco_q, troco_d;
    logic [CARTEIRA_W-1:0] carteira_q, carteira_d;
    logic                  erro_q, erro_d;
    logic [1:0]            prev_esc_q, prev_ins_q, prev_dar_q;

    logic       fire_esc, fire_ins, fire_dar, multi;
    logic       codigo_ok, moedas_ok;
    logic [7:0] preco_sel;
    logic [1:0] moeda;
    logic [7:0] moeda_cents;
    logic [7:0] mudanca;
    logic [7:0] resto_pos;
    logic [8:0] soma_d;

    function automatic logic [CARTEIRA_W-1:0] sat_add(input logic [CARTEIRA_W-1:0] a,
                                                      input logic [8:0] b);
        logic [CARTEIRA_W:0] s;
        s = {1'b0, a} + (CARTEIRA_W+1)'(b);
        return s[CARTEIRA_W] ? '1 : s[CARTEIRA_W-1:0];
    endfunction

    // A command fires only on its transition into 2'b01, so a held level acts once.
    assign fire_esc = (bus.escolher == 2'b01) && (prev_esc_q != 2'b01);
    assign fire_ins = (bus.inserir_dinheiro == 2'b01) && (prev_ins_q != 2'b01);
    assign fire_dar = (bus.dar_troco == 2'b01) && (prev_dar_q != 2'b01);
    assign multi    = (fire_esc && fire_ins) || (fire_esc && fire_dar) || (fire_ins && fire_dar);

    assign codigo_ok = (bus.produto_escolhido >= 8'd1) && (bus.produto_escolhido <= 8'd3);

    always_comb begin
        preco_sel = 8'd0;
        case (bus.produto_escolhido)
            8'd1:    preco_sel = 8'(PRECO_1);
            8'd2:    preco_sel = 8'(PRECO_2);
            8'd3:    preco_sel = 8'(PRECO_3);
            default: preco_sel = 8'd0;
        endcase
    end

`ifdef MAQ_VENDAS_VALIDA_MOEDAS_EN
    logic [15:0] soma_moedas;
    assign soma_moedas = 16'd25  * {8'd0, bus.moedas_inseridas[7:0]}
                       + 16'd50  * {8'd0, bus.moedas_inseridas[15:8]}
                       + 16'd100 * {8'd0, bus.moedas_inseridas[23:16]};
    assign moedas_ok = (soma_moedas == {8'd0, bus.dinheiro_inserido});
`else
    assign moedas_ok = 1'b1;
`endif

    always_comb begin
        moeda       = 2'd0;
        moeda_cents = 8'd0;
        if (resto_q >= 8'd100) begin
            moeda       = 2'd3;
            moeda_cents = 8'd100;
        end else if (resto_q >= 8'd50) begin
            moeda       = 2'd2;
            moeda_cents = 8'd50;
        end else if (resto_q >= 8'd25) begin
            moeda       = 2'd1;
            moeda_cents = 8'd25;
        end
    end

    assign resto_pos = resto_q - moeda_cents;
    assign mudanca   = (valor_q >= preco_q) ? (valor_q - preco_q) : valor_q;

    always_comb begin
        estado_d   = estado_q;
        codigo_d   = codigo_q;
        preco_d    = preco_q;
        valor_d    = valor_q;
        resto_d    = resto_q;
        liberado_d = liberado_q;
        troco_d    = troco_q;
        erro_d     = 1'b0;
        soma_d     = 9'd0;

        case (estado_q)
            OCIOSO, ESCOLHIDO: begin
                if (multi) begin
                    erro_d = 1'b1;
                end else if (fire_esc) begin
                    if (codigo_ok) begin
                        codigo_d   = bus.produto_escolhido;
                        preco_d    = preco_sel;
                        liberado_d = 8'd0;
                        troco_d    = 8'd0;
                        estado_d   = ESCOLHIDO;
                    end else begin
                        erro_d = 1'b1;
                    end
                end else if (estado_q == ESCOLHIDO && fire_ins) begin
                    if (moedas_ok) begin
                        valor_d  = bus.dinheiro_inserido;
                        estado_d = PAGO;
                    end else begin
                        erro_d = 1'b1;
                    end
                end else if (estado_q == ESCOLHIDO && fire_dar) begin
                    troco_d  = 8'd0;
                    estado_d = FIM;
                end
            end
            PAGO: begin
                if (multi || fire_esc || fire_ins) begin
                    erro_d = 1'b1;
                end else if (fire_dar) begin
                    troco_d = mudanca;
                    resto_d = mudanca;
                    if (valor_q >= preco_q) begin
                        liberado_d = codigo_q;
                        soma_d     = {1'b0, preco_q};
                    end
                    // Change too small for any coin skips dispensing and is kept as revenue.
                    if (mudanca >= 8'd25) begin
                        estado_d = DEVOLVE;
                    end else begin
                        soma_d   = soma_d + {1'b0, mudanca};
                        estado_d = FIM;
                    end
                end
            end
            DEVOLVE: begin
                resto_d = resto_pos;
                if (resto_pos < 8'd25) begin
                    soma_d   = {1'b0, resto_pos};
                    estado_d = FIM;
                end
            end
            FIM: begin
                estado_d = OCIOSO;
            end
            default: begin
                estado_d = OCIOSO;
            end
        endcase

        carteira_d = sat_add(carteira_q, soma_d);
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            estado_q   <= OCIOSO;
            codigo_q   <= 8'd0;
            preco_q    <= 8'd0;
            valor_q    <= 8'd0;
            resto_q    <= 8'd0;
            liberado_q <= 8'd0;
            troco_q    <= 8'd0;
            carteira_q <= '0;
            erro_q     <= 1'b0;
            prev_esc_q <= 2'b00;
            prev_ins_q <= 2'b00;
            prev_dar_q <= 2'b00;
        end else begin
            estado_q   <= estado_d;
            codigo_q   <= codigo_d;
            preco_q    <= preco_d;
            valor_q    <= valor_d;
            resto_q    <= resto_d;
            liberado_q <= liberado_d;
            troco_q    <= troco_d;
            carteira_q <= carteira_d;
            erro_q     <= erro_d;
            prev_esc_q <= bus.escolher;
            prev_ins_q <= bus.inserir_dinheiro;
            prev_dar_q <= bus.dar_troco;
        end
    end

    assign bus.produto_liberado = liberado_q;
    assign bus.troco            = troco_q;
    assign bus.moeda_valida     = (estado_q == DEVOLVE) && (moeda != 2'd0);
    assign bus.moeda_valor      = (estado_q == DEVOLVE) ? moeda : 2'd0;
    assign bus.carteira         = carteira_q;
    assign bus.concluido        = (estado_q == FIM);
    assign bus.erro             = erro_q;
    assign bus.estado           = estado_q;
endmodule

// File: tb/tb_maquina_vendas.sv
// tb/tb_maquina_vendas.sv - directed self-checking bench for maquina_vendas
module tb_maquina_vendas;
    logic clock;
    logic reset_n;
    int   n_checks;
    int   n_errors;
    int   wal;

    maquina_vendas_if #(.CARTEIRA_W(16)) bus ();

    maquina_vendas #(
        .PRECO_1(50), .PRECO_2(75), .PRECO_3(100), .CARTEIRA_W(16)
    ) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .bus    (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic snap(input string tag, input int est, input int lib, input int trc,
                        input int mv, input int mval, input int cart, input int conc, input int err);
        check({tag, ".estado"},   32'(bus.estado),           32'(est));
        check({tag, ".liberado"}, 32'(bus.produto_liberado), 32'(lib));
        check({tag, ".troco"},    32'(bus.troco),            32'(trc));
        check({tag, ".mvalida"},  32'(bus.moeda_valida),     32'(mv));
        check({tag, ".mvalor"},   32'(bus.moeda_valor),      32'(mval));
        check({tag, ".carteira"}, 32'(bus.carteira),         32'(cart));
        check({tag, ".concl"},    32'(bus.concluido),        32'(conc));
        check({tag, ".erro"},     32'(bus.erro),             32'(err));
    endtask

    task automatic sel(input logic [7:0] code);
        bus.produto_escolhido = code;
        bus.escolher = 2'b01;
        step();
        bus.escolher = 2'b00;
    endtask

    task automatic ins(input logic [7:0] amount, input logic [23:0] coins);
        bus.dinheiro_inserido = amount;
        bus.moedas_inseridas  = coins;
        bus.inserir_dinheiro  = 2'b01;
        step();
        bus.inserir_dinheiro  = 2'b00;
    endtask

    task automatic dar();
        bus.dar_troco = 2'b01;
        step();
        bus.dar_troco = 2'b00;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset_n = 1'b0;
        bus.escolher = 2'b00;
        bus.inserir_dinheiro = 2'b00;
        bus.dar_troco = 2'b00;
        bus.produto_escolhido = 8'd0;
        bus.dinheiro_inserido = 8'd0;
        bus.moedas_inseridas = 24'd0;
        step();
        step();
        snap("rst", 0, 0, 0, 0, 0, 0, 0, 0);
        reset_n = 1'b1;
        step();

        // product 1, pay 150 with one 50c and one 100c
        sel(8'd1);
        check("t1.sel", 32'(bus.estado), 32'd1);
        ins(8'd150, {8'd1, 8'd1, 8'd0});
        check("t1.ins", 32'(bus.estado), 32'd2);
        dar();
        snap("t1.c0", 3, 1, 100, 1, 3, 50, 0, 0);
        step();
        snap("t1.fim", 4, 1, 100, 0, 0, 50, 1, 0);
        step();
        snap("t1.idle", 0, 1, 100, 0, 0, 50, 0, 0);

        // product 2, pay 100 with two 25c and one 50c
        sel(8'd2);
        snap("t2.sel", 1, 0, 0, 0, 0, 50, 0, 0);
        ins(8'd100, {8'd0, 8'd1, 8'd2});
        dar();
        snap("t2.c0", 3, 2, 25, 1, 1, 125, 0, 0);
        step();
        snap("t2.fim", 4, 2, 25, 0, 0, 125, 1, 0);
        step();

        // product 3 underpaid: full refund 50 + 25
        sel(8'd3);
        ins(8'd75, {8'd0, 8'd1, 8'd1});
        dar();
        snap("t3.c0", 3, 0, 75, 1, 2, 125, 0, 0);
        step();
        snap("t3.c1", 3, 0, 75, 1, 1, 125, 0, 0);
        step();
        snap("t3.fim", 4, 0, 75, 0, 0, 125, 1, 0);
        step();

        // invalid code, then simultaneous commands
        sel(8'd0);
        snap("t4.bad", 0, 0, 75, 0, 0, 125, 0, 1);
        step();
        check("t4.erro_off", 32'(bus.erro), 32'd0);
        bus.produto_escolhido = 8'd1;
        bus.escolher = 2'b01;
        bus.inserir_dinheiro = 2'b01;
        step();
        bus.escolher = 2'b00;
        bus.inserir_dinheiro = 2'b00;
        snap("t4.dual", 0, 0, 75, 0, 0, 125, 0, 1);
        step();
        snap("t4.after", 0, 0, 75, 0, 0, 125, 0, 0);

`ifndef MAQ_VENDAS_VALIDA_MOEDAS_EN
        // 255 for product 1: coins 100,100, reset during the second coin
        sel(8'd1);
        ins(8'd255, 24'd0);
        dar();
        snap("t5.c0", 3, 1, 205, 1, 3, 175, 0, 0);
        step();
        snap("t5.c1", 3, 1, 205, 1, 3, 175, 0, 0);
        reset_n = 1'b0;
        step();
        snap("t5.rst", 0, 0, 0, 0, 0, 0, 0, 0);
        reset_n = 1'b1;
        step();

        // same sale to completion: 5c remainder goes to the wallet
        sel(8'd1);
        ins(8'd255, 24'd0);
        dar();
        snap("t6.c0", 3, 1, 205, 1, 3, 50, 0, 0);
        step();
        snap("t6.c1", 3, 1, 205, 1, 3, 50, 0, 0);
        step();
        snap("t6.fim", 4, 1, 205, 0, 0, 55, 1, 0);
        step();
        wal = 55;
`else
        // coin counts must add up to the inserted amount
        sel(8'd1);
        ins(8'd150, {8'd1, 8'd1, 8'd1});
        snap("m.bad", 1, 0, 0, 0, 0, 125, 0, 1);
        step();
        ins(8'd150, {8'd1, 8'd1, 8'd0});
        snap("m.ok", 2, 0, 0, 0, 0, 125, 0, 0);
        dar();
        snap("m.c0", 3, 1, 100, 1, 3, 175, 0, 0);
        step();
        snap("m.fim", 4, 1, 100, 0, 0, 175, 1, 0);
        step();
        wal = 175;
`endif

        // cancel from ESCOLHIDO
        sel(8'd2);
        dar();
        snap("t7.cancel", 4, 0, 0, 0, 0, wal, 1, 0);
        step();
        check("t7.idle", 32'(bus.estado), 32'd0);

        // exact payment, plus an extra insert in PAGO
        sel(8'd3);
        ins(8'd100, {8'd1, 8'd0, 8'd0});
        step();
        ins(8'd100, {8'd1, 8'd0, 8'd0});
        snap("t8.reins", 2, 0, 0, 0, 0, wal, 0, 1);
        dar();
        snap("t8.zero", 4, 3, 0, 0, 0, wal + 100, 1, 0);
        step();
        snap("t8.idle", 0, 3, 0, 0, 0, wal + 100, 0, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
